// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller:
// FSM states, opcodes, ALU operations, immediate formats and mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALTGT   = 4'd10,
      S_JAL      = 4'd11,
      S_LUI      = 4'd12
   } ctrl_state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to the ALU operation for register and immediate
// arithmetic; instr[30] only selects SUB for register ops, SRA for both.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (funct3)
         3'b000:  alu_ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_ctrl = ALU_SLL;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b011:  alu_ctrl = ALU_SLTU;
         3'b100:  alu_ctrl = ALU_XOR;
         3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_ctrl = ALU_OR;
         3'b111:  alu_ctrl = ALU_AND;
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXECUTE/MEM/WB one state per
// clock and drives every datapath enable and mux select from the current state.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  EQ,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  IRWrite,
   output logic                  AdrSrc,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [3:0]            ALUctrl,
   output logic [2:0]            ImmSrc,
   output logic [1:0]            ResultSrc,
   output logic                  instr_done,
   output logic                  illegal,
   output ctrl_state_t           state_dbg
);

   ctrl_state_t state_q, state_d;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [3:0]  dec_alu_ctrl;
   logic        unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};
   assign state_dbg         = state_q;

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7_5 (instr[30]),
      .is_rtype (state_q == S_EXECR),
      .alu_ctrl (dec_alu_ctrl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUctrl    = ALU_ADD;
      ImmSrc     = IMM_I;
      ResultSrc  = RES_ALUOUT;
      instr_done = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         // Precompute the B-format target into ALUOut while the opcode decodes.
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JALTGT;
               OP_LUI:            state_d = S_LUI;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemRead = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            ResultSrc  = RES_MEM;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUctrl = dec_alu_ctrl;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_I;
            ALUctrl = dec_alu_ctrl;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            ResultSrc  = RES_ALUOUT;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         // ALUOut still holds the target from DECODE, so a taken branch loads it.
         S_BRANCH: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_RS2;
            ALUctrl   = ALU_SUB;
            ResultSrc = RES_ALUOUT;
            state_d   = S_FETCH;
            case (funct3)
               3'b000: begin
                  PCWrite    = EQ;
                  instr_done = 1'b1;
               end
               3'b001: begin
                  PCWrite    = ~EQ;
                  instr_done = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         S_JALTGT: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_J;
            state_d = S_JAL;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ImmSrc    = IMM_J;
            ResultSrc = RES_ALUOUT;
            PCWrite   = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_U;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset aborts mid-instruction: nothing may reach the datapath.
      if (rst) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ALUctrl    = 4'b0000;
         ImmSrc     = 3'b000;
         ResultSrc  = 2'b00;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule
